irq_priority_encoder: RTL and testbench



---
 rtl/irq_pkg.sv | 20 ++
 rtl/priority_encoder_8to3.sv | 25 ++
 rtl/irq_priority_encoder.sv | 106 ++++++++++
 tb/tb_irq_priority_encoder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared constants, FSM state type and ID helper for the interrupt encoder
// Contents:
//   N_IRQ, IRQ_ID_W : source count and ID width
//   irq_state_e     : presentation FSM states
//   id_onehot()     : binary source ID to one-hot source vector
package irq_pkg;

    localparam int N_IRQ    = 8;
    localparam int IRQ_ID_W = 3;

    typedef enum logic [0:0] {
        IRQ_IDLE    = 1'b0,
        IRQ_PRESENT = 1'b1
    } irq_state_e;

    function automatic logic [N_IRQ-1:0] id_onehot(input logic [IRQ_ID_W-1:0] id);
        return N_IRQ'(1) << id;
    endfunction

endpackage

// File: rtl/priority_encoder_8to3.sv
// rtl/priority_encoder_8to3.sv - combinational 8-to-3 encoder, highest set bit wins
// Ports:
//   vec_i : input vector, bit 7 highest priority
//   any_o : at least one bit of vec_i is set
//   idx_o : index of the highest set bit (0 when vec_i is zero)
module priority_encoder_8to3
    import irq_pkg::*;
(
    input  logic [N_IRQ-1:0]    vec_i,
    output logic                any_o,
    output logic [IRQ_ID_W-1:0] idx_o
);

    // Ascending scan: later (higher) indices overwrite earlier ones.
    always_comb begin
        idx_o = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            if (vec_i[i]) begin
                idx_o = IRQ_ID_W'(i);
            end
        end
        any_o = |vec_i;
    end

endmodule

// File: rtl/irq_priority_encoder.sv
// rtl/irq_priority_encoder.sv - interrupt request capture, masking and priority presentation
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   req                  : request lines, bit 7 highest priority
//   mask_we, mask_wdata  : mask register write (1 = source masked)
//   ack                  : consumer accepts the presented ID
//   irq_valid, irq_id    : presented interrupt source
//   pending, mask        : current pending and mask registers
module irq_priority_encoder
    import irq_pkg::*;
#(
    parameter bit EDGE = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_IRQ-1:0]    req,
    input  logic                mask_we,
    input  logic [N_IRQ-1:0]    mask_wdata,
    input  logic                ack,
    output logic                irq_valid,
    output logic [IRQ_ID_W-1:0] irq_id,
    output logic [N_IRQ-1:0]    pending,
    output logic [N_IRQ-1:0]    mask
);

    logic [N_IRQ-1:0]    req_q;
    logic [N_IRQ-1:0]    pending_q;
    logic [N_IRQ-1:0]    pending_d;
    logic [N_IRQ-1:0]    mask_q;
    logic [N_IRQ-1:0]    mask_d;
    logic [N_IRQ-1:0]    cap;
    logic [N_IRQ-1:0]    clr;
    logic [N_IRQ-1:0]    eligible;
    logic                enc_any;
    logic [IRQ_ID_W-1:0] enc_idx;
    irq_state_e          state_q;
    logic                irq_valid_q;
    logic [IRQ_ID_W-1:0] irq_id_q;

    always_comb begin
        // req_q is zero out of reset, so a line already high at release
        // is seen as a rising edge on the first clock.
        cap = EDGE ? (req & ~req_q) : req;
        clr = '0;
        if (ack && irq_valid_q) begin
            clr = id_onehot(irq_id_q);
        end
        // Capture is OR-ed after the clear so a fresh event on the
        // acknowledged source is never dropped.
        pending_d = (pending_q & ~clr) | cap;
        mask_d    = mask_we ? mask_wdata : mask_q;
        // Selection uses registered pending/mask only, keeping the
        // request-to-presentation path fully registered.
        eligible  = pending_q & ~mask_q;
    end

    priority_encoder_8to3 u_enc (
        .vec_i (eligible),
        .any_o (enc_any),
        .idx_o (enc_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q     <= '0;
            pending_q <= '0;
            mask_q    <= '0;
        end else begin
            req_q     <= req;
            pending_q <= pending_d;
            mask_q    <= mask_d;
        end
    end

    // Once presented, the ID is held until acknowledged; a later
    // higher-priority request or masking of the source does not withdraw it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IRQ_IDLE;
            irq_valid_q <= 1'b0;
            irq_id_q    <= '0;
        end else begin
            case (state_q)
                IRQ_IDLE: begin
                    if (enc_any) begin
                        irq_id_q    <= enc_idx;
                        irq_valid_q <= 1'b1;
                        state_q     <= IRQ_PRESENT;
                    end
                end
                IRQ_PRESENT: begin
                    if (ack) begin
                        irq_valid_q <= 1'b0;
                        state_q     <= IRQ_IDLE;
                    end
                end
            endcase
        end
    end

    assign irq_valid = irq_valid_q;
    assign irq_id    = irq_id_q;
    assign pending   = pending_q;
    assign mask      = mask_q;

endmodule

// File: tb/tb_irq_priority_encoder.sv
// tb/tb_irq_priority_encoder.sv - self-checking bench for irq_priority_encoder (edge and level instances)
module tb_irq_priority_encoder;

    typedef struct packed {
        logic [7:0] pend;
        logic [7:0] mask;
        logic [7:0] prev;
        logic       busy;
        logic [2:0] id;
    } mstate_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req_e = '0, mwd_e = '0, req_l = '0, mwd_l = '0;
    logic       mwe_e = 1'b0, ack_e = 1'b0, mwe_l = 1'b0, ack_l = 1'b0;
    logic       val_e, val_l;
    logic [2:0] id_e, id_l;
    logic [7:0] pend_e, mask_e, pend_l, mask_l;
    logic [11:0] snap_e, snap_l, exp;
    mstate_t    me, ml;
    int         n_tests = 0;
    int         n_fail  = 0;

    always #5 clk = ~clk;

    irq_priority_encoder #(.EDGE(1'b1)) dut_e (
        .clk(clk), .rst(rst), .req(req_e), .mask_we(mwe_e), .mask_wdata(mwd_e), .ack(ack_e),
        .irq_valid(val_e), .irq_id(id_e), .pending(pend_e), .mask(mask_e)
    );

    irq_priority_encoder #(.EDGE(1'b0)) dut_l (
        .clk(clk), .rst(rst), .req(req_l), .mask_we(mwe_l), .mask_wdata(mwd_l), .ack(ack_l),
        .irq_valid(val_l), .irq_id(id_l), .pending(pend_l), .mask(mask_l)
    );

    // ID is only meaningful while valid, so it is zeroed in the snapshot otherwise.
    always_comb snap_e = {val_e, val_e ? id_e : 3'd0, pend_e};
    always_comb snap_l = {val_l, val_l ? id_l : 3'd0, pend_l};

    // Reference model: one interrupt controller step from the behavioural rules.
    function automatic mstate_t mstep(mstate_t s, bit edge_mode, logic [7:0] r, logic a,
                                      logic we, logic [7:0] wd);
        mstate_t n = s;
        bit      found = 0;
        if (s.busy && a) begin
            n.pend[s.id] = 1'b0;
            n.busy = 1'b0;
        end else if (!s.busy) begin
            for (int i = 7; i >= 0; i--) begin
                if (!found && s.pend[i] && !s.mask[i]) begin
                    found  = 1;
                    n.busy = 1'b1;
                    n.id   = 3'(i);
                end
            end
        end
        for (int i = 0; i < 8; i++) begin
            if (r[i] && (!edge_mode || !s.prev[i])) n.pend[i] = 1'b1;
        end
        if (we) n.mask = wd;
        n.prev = r;
        return n;
    endfunction

    function automatic logic [11:0] msnap(mstate_t s);
        return {s.busy, s.busy ? s.id : 3'd0, s.pend};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            me <= '0;
            ml <= '0;
        end else begin
            me <= mstep(me, 1'b1, req_e, ack_e, mwe_e, mwd_e);
            ml <= mstep(ml, 1'b0, req_l, ack_l, mwe_l, mwd_l);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_e = '0; mwe_e = 0; mwd_e = '0; ack_e = 0;
        req_l = '0; mwe_l = 0; mwd_l = '0; ack_l = 0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if ({snap_e, mask_e} !== 20'h0) begin n_fail++; $display("FAIL reset_init got %h exp 00000", {snap_e, mask_e}); end
        req_e = 8'h02; mwe_e = 1; mwd_e = 8'h40; tick();
        req_e = 8'h00; mwe_e = 0; tick();
        exp = {1'b1, 3'd1, 8'h02};
        n_tests++; if (snap_e !== exp || mask_e !== 8'h40) begin n_fail++; $display("FAIL reset_pre got %h/%h exp %h/40", snap_e, mask_e, exp); end
        #2; rst = 1'b1; #1;
        n_tests++; if ({val_e, id_e, pend_e, mask_e} !== 20'h0) begin n_fail++; $display("FAIL reset_async got %h exp 00000", {val_e, id_e, pend_e, mask_e}); end
        tick(); rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++; if (snap_e !== 12'h0) begin n_fail++; $display("FAIL reset_quiet got %h exp 000", snap_e); end
        end
        rst = 1'b1; req_e = 8'h01; tick(); rst = 1'b0;
        tick();
        exp = {1'b0, 3'd0, 8'h01};
        n_tests++; if (snap_e !== exp) begin n_fail++; $display("FAIL reset_release_edge got %h exp %h", snap_e, exp); end
        req_e = 8'h00;
    endtask

    task automatic test_single();
        do_reset();
        req_e = 8'h20; tick();
        exp = {1'b0, 3'd0, 8'h20};
        n_tests++; if (snap_e !== exp) begin n_fail++; $display("FAIL single_pend got %h exp %h", snap_e, exp); end
        req_e = 8'h00; tick();
        exp = {1'b1, 3'd5, 8'h20};
        n_tests++; if (snap_e !== exp) begin n_fail++; $display("FAIL single_present got %h exp %h", snap_e, exp); end
        ack_e = 1; tick(); ack_e = 0;
        n_tests++; if (snap_e !== 12'h0) begin n_fail++; $display("FAIL single_ack got %h exp 000", snap_e); end
    endtask

    task automatic test_priority();
        do_reset();
        req_e = 8'h12; tick(); req_e = 8'h00; tick();
        exp = {1'b1, 3'd4, 8'h12};
        n_tests++; if (snap_e !== exp) begin n_fail++; $display("FAIL prio_first got %h exp %h", snap_e, exp); end
        ack_e = 1; tick(); ack_e = 0;
        exp = {1'b0, 3'd0, 8'h02};
        n_tests++; if (snap_e !== exp) begin n_fail++; $display("FAIL prio_idle_gap got %h exp %h", snap_e, exp); end
        tick();
        exp = {1'b1, 3'd1, 8'h02};
        n_tests++; if (snap_e !== exp) begin n_fail++; $display("FAIL prio_second got %h exp %h", snap_e, exp); end
        ack_e = 1; tick(); ack_e = 0;
        n_tests++; if (snap_e !== 12'h0) begin n_fail++; $display("FAIL prio_drain got %h exp 000", snap_e); end
    endtask

    task automatic test_frozen();
        do_reset();
        req_e = 8'h02; tick(); req_e = 8'h00; tick();
        req_e = 8'h80; tick(); req_e = 8'h00;
        exp = {1'b1, 3'd1, 8'h82};
        n_tests++; if (snap_e !== exp) begin n_fail++; $display("FAIL frozen_hold1 got %h exp %h", snap_e, exp); end
        tick();
        n_tests++; if (snap_e !== exp) begin n_fail++; $display("FAIL frozen_hold2 got %h exp %h", snap_e, exp); end
        ack_e = 1; tick(); ack_e = 0;
        exp = {1'b0, 3'd0, 8'h80};
        n_tests++; if (snap_e !== exp) begin n_fail++; $display("FAIL frozen_ack got %h exp %h", snap_e, exp); end
        tick();
        exp = {1'b1, 3'd7, 8'h80};
        n_tests++; if (snap_e !== exp) begin n_fail++; $display("FAIL frozen_next got %h exp %h", snap_e, exp); end
    endtask

    task automatic test_mask();
        do_reset();
        mwe_e = 1; mwd_e = 8'h80; tick(); mwe_e = 0;
        n_tests++; if (mask_e !== 8'h80) begin n_fail++; $display("FAIL mask_write got %h exp 80", mask_e); end
        req_e = 8'h80; tick(); req_e = 8'h00;
        exp = {1'b0, 3'd0, 8'h80};
        n_tests++; if (snap_e !== exp) begin n_fail++; $display("FAIL mask_pend got %h exp %h", snap_e, exp); end
        ack_e = 1; tick(); ack_e = 0;
        n_tests++; if (snap_e !== exp) begin n_fail++; $display("FAIL mask_idle_ack got %h exp %h", snap_e, exp); end
        tick();
        n_tests++; if (snap_e !== exp) begin n_fail++; $display("FAIL mask_hold got %h exp %h", snap_e, exp); end
        mwe_e = 1; mwd_e = 8'h00; tick(); mwe_e = 0;
        n_tests++; if (snap_e !== exp || mask_e !== 8'h00) begin n_fail++; $display("FAIL mask_clear got %h/%h exp %h/00", snap_e, mask_e, exp); end
        tick();
        exp = {1'b1, 3'd7, 8'h80};
        n_tests++; if (snap_e !== exp) begin n_fail++; $display("FAIL mask_unmasked got %h exp %h", snap_e, exp); end
    endtask

    task automatic test_set_clear();
        do_reset();
        req_e = 8'h08; tick(); req_e = 8'h00; tick();
        exp = {1'b1, 3'd3, 8'h08};
        n_tests++; if (snap_e !== exp) begin n_fail++; $display("FAIL setclr_present got %h exp %h", snap_e, exp); end
        req_e = 8'h08; ack_e = 1; tick(); req_e = 8'h00; ack_e = 0;
        exp = {1'b0, 3'd0, 8'h08};
        n_tests++; if (snap_e !== exp) begin n_fail++; $display("FAIL setclr_setwins got %h exp %h", snap_e, exp); end
        tick();
        exp = {1'b1, 3'd3, 8'h08};
        n_tests++; if (snap_e !== exp) begin n_fail++; $display("FAIL setclr_represent got %h exp %h", snap_e, exp); end
        ack_e = 1; tick(); ack_e = 0;
        n_tests++; if (snap_e !== 12'h0) begin n_fail++; $display("FAIL setclr_drain got %h exp 000", snap_e); end
    endtask

    task automatic test_level();
        do_reset();
        req_l = 8'h04; tick();
        exp = {1'b0, 3'd0, 8'h04};
        n_tests++; if (snap_l !== exp) begin n_fail++; $display("FAIL level_pend got %h exp %h", snap_l, exp); end
        tick();
        for (int k = 0; k < 3; k++) begin
            exp = {1'b1, 3'd2, 8'h04};
            n_tests++; if (snap_l !== exp) begin n_fail++; $display("FAIL level_present%0d got %h exp %h", k, snap_l, exp); end
            ack_l = 1; tick(); ack_l = 0;
            exp = {1'b0, 3'd0, 8'h04};
            n_tests++; if (snap_l !== exp) begin n_fail++; $display("FAIL level_reset_after_ack%0d got %h exp %h", k, snap_l, exp); end
            tick();
        end
        req_l = 8'h00; ack_l = 1; tick(); ack_l = 0;
        n_tests++; if (snap_l !== 12'h0) begin n_fail++; $display("FAIL level_drain got %h exp 000", snap_l); end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            req_e = 8'($urandom & $urandom & $urandom);
            req_l = 8'($urandom & $urandom & $urandom);
            ack_e = 1'($urandom_range(0, 1));
            ack_l = 1'($urandom_range(0, 1));
            mwe_e = ($urandom_range(0, 7) == 0);
            mwe_l = ($urandom_range(0, 7) == 0);
            mwd_e = 8'($urandom & $urandom);
            mwd_l = 8'($urandom & $urandom);
            tick();
            n_tests++; if ({snap_e, mask_e} !== {msnap(me), me.mask}) begin n_fail++; $display("FAIL rand_edge cyc %0d got %h exp %h", n, {snap_e, mask_e}, {msnap(me), me.mask}); end
            n_tests++; if ({snap_l, mask_l} !== {msnap(ml), ml.mask}) begin n_fail++; $display("FAIL rand_level cyc %0d got %h exp %h", n, {snap_l, mask_l}, {msnap(ml), ml.mask}); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_frozen();
        test_mask();
        test_set_clear();
        test_level();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
